// File: rtl/dot_product_seq.sv
// rtl/dot_product_seq.sv - matrix-vector sequencer feeding a shared combinational dot_product
// Optional macro DOT_PRODUCT_SEQ_DPREG_EN inserts a register on dp_outp (adds EVAL2 state).
module dot_product_seq #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int NB = 3,
    parameter int RW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [RW-1:0]         num_rows,
    output logic                  busy,
    output logic                  done,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [N*DW-1:0]       vec_data,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [N*DW-1:0]       row_data,
    output logic [N*DW-1:0]       dp_inp1,
    output logic [N*DW-1:0]       dp_inp2,
    input  logic [2*DW+NB-1:0]    dp_outp,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DW+NB-1:0]    res_data,
    output logic [RW-1:0]         res_idx,
    output logic                  res_last
);
    localparam int VW = N * DW;
    localparam int OW = 2 * DW + NB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_VEC,
        S_ROW,
        S_EVAL,
        S_EVAL2,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [RW-1:0]   num_rows_q, num_rows_d;
    logic [RW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   dp_inp1_q, dp_inp1_d;
    logic [VW-1:0]   dp_inp2_q, dp_inp2_d;
    logic            res_valid_q, res_valid_d;
    logic [OW-1:0]   res_data_q, res_data_d;
    logic [RW-1:0]   res_idx_q, res_idx_d;
    logic            res_last_q, res_last_d;
`ifdef DOT_PRODUCT_SEQ_DPREG_EN
    logic [OW-1:0]   dpreg_q, dpreg_d;
`endif

    logic            res_xfer;
    logic            capture;
    logic            is_last;
    logic [OW-1:0]   cap_src;

    assign res_xfer  = res_valid_q && res_ready;
    assign is_last   = (cnt_q == num_rows_q - RW'(1));
    // A new row is only taken when its result will have a free output slot.
    assign row_ready = (state_q == S_ROW) && (!res_valid_q || res_ready);
    assign vec_ready = (state_q == S_LOAD_VEC);

`ifdef DOT_PRODUCT_SEQ_DPREG_EN
    assign cap_src = dpreg_q;
`else
    assign cap_src = dp_outp;
`endif

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        num_rows_d  = num_rows_q;
        cnt_d       = cnt_q;
        dp_inp1_d   = dp_inp1_q;
        dp_inp2_d   = dp_inp2_q;
        res_valid_d = res_xfer ? 1'b0 : res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_last_d  = res_last_q;
        capture     = 1'b0;
`ifdef DOT_PRODUCT_SEQ_DPREG_EN
        dpreg_d     = dpreg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        num_rows_d = num_rows;
                        busy_d     = 1'b1;
                        state_d    = S_LOAD_VEC;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD_VEC: begin
                if (vec_valid) begin
                    dp_inp2_d = vec_data;
                    cnt_d     = '0;
                    state_d   = S_ROW;
                end
            end
            S_ROW: begin
                if (row_valid && row_ready) begin
                    dp_inp1_d = row_data;
                    state_d   = S_EVAL;
                end
            end
            S_EVAL: begin
`ifdef DOT_PRODUCT_SEQ_DPREG_EN
                dpreg_d = dp_outp;
                state_d = S_EVAL2;
`else
                capture = 1'b1;
`endif
            end
            S_EVAL2: begin
`ifdef DOT_PRODUCT_SEQ_DPREG_EN
                capture = 1'b1;
`else
                state_d = S_IDLE;
`endif
            end
            S_DRAIN: begin
                if (res_xfer) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            res_data_d  = cap_src;
            res_idx_d   = cnt_q;
            res_last_d  = is_last;
            res_valid_d = 1'b1;
            if (is_last) begin
                state_d = S_DRAIN;
            end else begin
                cnt_d   = cnt_q + RW'(1);
                state_d = S_ROW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            num_rows_q  <= '0;
            cnt_q       <= '0;
            dp_inp1_q   <= '0;
            dp_inp2_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_last_q  <= 1'b0;
`ifdef DOT_PRODUCT_SEQ_DPREG_EN
            dpreg_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            num_rows_q  <= num_rows_d;
            cnt_q       <= cnt_d;
            dp_inp1_q   <= dp_inp1_d;
            dp_inp2_q   <= dp_inp2_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_last_q  <= res_last_d;
`ifdef DOT_PRODUCT_SEQ_DPREG_EN
            dpreg_q     <= dpreg_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dp_inp1   = dp_inp1_q;
    assign dp_inp2   = dp_inp2_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign res_last  = res_last_q;
endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
- Matrix-vector sequencer for the shared combinational dot_product datapath.
- Latches one operand vector, then streams num_rows row vectors through dot_product one at a time.
- Returns each row's inner product on a valid/ready result port, tagged with its row index and a last flag.
- Sits between the operand buffers and the dot_product instance; drives dot_product inp1/inp2 from registers and samples outp.

Parameters:
- N, 8, elements per vector.
- DW, 8, element width (unsigned).
- NB, 3, clog2(N); result width is 2*DW+NB.
- RW, 8, row counter / num_rows width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job start pulse; ignored while busy.
- num_rows  in  RW  rows in the job; sampled when start is accepted.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the job completes.
- vec_valid / vec_ready  in / out  1  operand-vector handshake.
- vec_data  in  N*DW  operand vector; element 0 in bits [N*DW-1 -: DW].
- row_valid / row_ready  in / out  1  row handshake.
- row_data  in  N*DW  row vector, same packing as vec_data.
- dp_inp1  out  N*DW  registered row to dot_product inp1.
- dp_inp2  out  N*DW  registered vector to dot_product inp2.
- dp_outp  in  2*DW+NB  dot_product result (combinational).
- res_valid / res_ready  out / in  1  result handshake.
- res_data  out  2*DW+NB  captured inner product.
- res_idx  out  RW  row index of res_data, 0-based.
- res_last  out  1  res_data belongs to row num_rows-1.

Behaviour:
- Reset values: busy, done, vec_ready, row_ready and res_valid are 0. res_data, res_idx, res_last, dp_inp1 and dp_inp2 are 0. State is IDLE and the row counter is 0.
- Handshake: a transfer occurs on a cycle where valid and ready are both high at the rising edge.
- IDLE:
  - start with num_rows != 0: latch num_rows, set busy, go to LOAD_VEC.
  - start with num_rows == 0: done pulses next cycle, busy stays 0, remain in IDLE.
- LOAD_VEC: vec_ready=1. On transfer, dp_inp2 <= vec_data, counter <= 0, go to ROW.
- ROW: row_ready = !res_valid || res_ready, i.e. the output slot is free or draining this cycle. On transfer, dp_inp1 <= row_data, go to EVAL.
- EVAL: row_ready=0. Capture res_data <= dp_outp, res_idx <= counter, res_last <= (counter == num_rows-1), res_valid <= 1.
  - If last, go to DRAIN; otherwise counter++ and go to ROW.
- DRAIN: wait for the res_valid && res_ready transfer. Next cycle: done=1, busy=0, state IDLE.
- res_valid clears on a transfer unless a new capture occurs in the same cycle. While res_valid && !res_ready, res_data, res_idx and res_last are held stable.
- Latency: row transfer to res_valid is 2 cycles. Peak throughput is one row per 2 cycles.
- vec_ready and row_ready are low in all states other than those listed above.
- start while busy: ignored, no effect on the current job.
- dp_inp2 holds the vector for the whole job. dp_inp1 holds the last row until the next row transfer.
- num_rows = 2^RW-1 is supported; the counter never wraps within a job.
- rst mid-job: immediate return to reset values and state. No done pulse; any pending result is discarded.

Optional Feature:
- Macro: DOT_PRODUCT_SEQ_DPREG_EN.
- Defined: adds an EVAL2 state. EVAL registers dp_outp into an internal pipeline register; EVAL2 captures that register into res_data and performs the EVAL transitions above. Latency becomes 3 cycles, throughput one row per 3 cycles. Use this to break the dot_product combinational path.
- Undefined: behaviour exactly as in Behaviour, with no extra register.

Test Plan:
- Basic: num_rows=1; vec = row = 64'h0000_0000_0000_0204. Result: res_data=20, res_idx=0, res_last=1 two cycles after the row transfer. done pulses the cycle after the result transfer.
- Max values: num_rows=2, vec all 8'hFF, rows all 8'hFF then all 8'h01.
  - Row 0: res_data=520200.
  - Row 1: res_data=2040.
  - res_idx is 0 then 1; res_last is set only on row 1.
- Backpressure: num_rows=3, res_ready held 0 for 5 cycles after the first result.
  - res_data and res_idx stay stable during the stall.
  - row_ready stays 0 during the stall.
  - All three results arrive in order once res_ready=1.
- Zero rows / busy start: start with num_rows=0 gives one done pulse and no handshakes. A second start issued mid-job is ignored and the job count is unchanged.
- Reset mid-job: assert rst in EVAL of row 1 of 4. Next cycle all outputs are at reset values with no done pulse; a fresh num_rows=1 job then completes correctly.
- With DOT_PRODUCT_SEQ_DPREG_EN: rerun the basic test. res_valid asserts 3 cycles after the row transfer, with res_data=20.
